spi_regmap_burst: RTL and testbench

Parametrised SPI-slave register map, the successor to the fixed 12-config/4-status SPI register map used in our Tiny Tapeout tiles. It decodes mode-0 SPI frames of R/W bit, address and data, MSB first, and serves three address regions:
- a bank of read/write configuration registers;
- a bank of read-only status inputs;
- an unmapped region.

Width, depth and address size are parameters. An optional auto-increment burst mode is compiled in by macro. The block sits between the tile's uio SPI pins and the core logic.

---
 rtl/spi_regmap_pkg.sv | 35 +++
 rtl/spi_regmap_burst_in_sync.sv | 40 ++++
 rtl/spi_regmap_burst.sv | 212 +++++++++++++++++++++
 tb/tb_spi_regmap_burst.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spi_regmap_pkg.sv
// Shared types and helpers for the SPI register map:
// FSM states, frame field widths and the address region decoder.
package spi_regmap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_HOLD
   } state_e;

   typedef enum logic [1:0] {
      RGN_CONFIG,
      RGN_STATUS,
      RGN_UNMAPPED
   } region_e;

   localparam int RW_BITS        = 1;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int CNT_W          = 8;

   function automatic region_e decode_region(input logic [31:0] addr,
                                             input int          num_cfg,
                                             input int          num_sts);
      if (addr < 32'(num_cfg))
         return RGN_CONFIG;
      else if (addr < 32'(num_cfg + num_sts))
         return RGN_STATUS;
      else
         return RGN_UNMAPPED;
   endfunction

endpackage

// File: rtl/spi_regmap_burst_in_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rising and
// falling edge pulses derived from the synchronised level.
module spi_in_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regmap_burst.sv
// Mode-0 SPI slave register map: R/W config bank, read-only status bank.
// Define SPI_REGMAP_BURST_EN to enable auto-increment burst transfers.
module spi_regmap_burst
   import spi_regmap_pkg::*;
#(
   parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int                    NUM_CONFIG_REG = 12,
   parameter int                    NUM_STATUS_REG = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL      = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 sck_i,
   input  logic                                 sdi_i,
   input  logic                                 cs_ni,
   output logic                                 sdo_o,
   output logic                                 sdo_oe,
   output logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] config_o,
   input  logic [NUM_STATUS_REG*DATA_WIDTH-1:0] status_i,
   output logic                                 wr_strobe_o,
   output logic [ADDR_WIDTH-1:0]                wr_addr_o
);

   localparam int NUM_REG = NUM_CONFIG_REG + NUM_STATUS_REG;
   localparam int CFG_W   = NUM_CONFIG_REG * DATA_WIDTH;

   logic sck_sync, sck_rise, sck_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic unused_sync;

   // cs resets to "selected" so a frame already in flight at reset release never sees a falling edge
   spi_in_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst_n(rst_n), .d_i(sck_i),
      .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall));
   spi_in_sync #(.RST_VAL(1'b0)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .d_i(cs_ni),
      .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall));

   assign unused_sync = &{1'b0, sck_sync, cs_rise};

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    rw_q, rw_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    load_q, load_d;
   logic                    sdo_q, sdo_d;
   logic                    sdo_oe_q, sdo_oe_d;
   logic [CFG_W-1:0]        cfg_q, cfg_d;
   logic                    strobe_q, strobe_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic                    sdi_meta_q, sdi_meta_d;
   logic                    sdi_sync_q, sdi_sync_d;
   logic [DATA_WIDTH-1:0]   word_v;
   logic [DATA_WIDTH-1:0]   rd_v;

   function automatic logic [DATA_WIDTH-1:0] read_word(
      input logic [ADDR_WIDTH-1:0]                a,
      input logic [CFG_W-1:0]                     cfg,
      input logic [NUM_STATUS_REG*DATA_WIDTH-1:0] sts);
      logic [DATA_WIDTH-1:0] w;
      w = '0;
      case (decode_region(32'(a), NUM_CONFIG_REG, NUM_STATUS_REG))
         RGN_CONFIG:
            for (int k = 0; k < NUM_CONFIG_REG; k++)
               if (a == ADDR_WIDTH'(k)) w = cfg[k*DATA_WIDTH +: DATA_WIDTH];
         RGN_STATUS:
            for (int k = 0; k < NUM_STATUS_REG; k++)
               if (a == ADDR_WIDTH'(NUM_CONFIG_REG + k)) w = sts[k*DATA_WIDTH +: DATA_WIDTH];
         default: w = '0;
      endcase
      return w;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      din_d      = din_q;
      dout_d     = dout_q;
      load_d     = load_q;
      sdo_d      = sdo_q;
      cfg_d      = cfg_q;
      strobe_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      sdi_meta_d = sdi_i;
      sdi_sync_d = sdi_meta_q;
      word_v     = {din_q[DATA_WIDTH-2:0], sdi_sync_q};
      rd_v       = read_word(addr_q, cfg_q, status_i);

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
         end
         ST_CMD: begin
            if (sck_rise) begin
               rw_d = sdi_sync_q;
               if (cnt_q == CNT_W'(RW_BITS - 1)) begin
                  state_d = ST_ADDR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (sck_rise) begin
               addr_d = {addr_q[ADDR_WIDTH-2:0], sdi_sync_q};
               if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  load_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (sck_fall) begin
               if (load_q) begin
                  dout_d = rd_v;
                  sdo_d  = rd_v[DATA_WIDTH-1];
                  load_d = 1'b0;
               end else begin
                  dout_d = {dout_q[DATA_WIDTH-2:0], 1'b0};
                  sdo_d  = dout_q[DATA_WIDTH-2];
               end
            end
            if (sck_rise) begin
               din_d = word_v;
               if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  cnt_d = '0;
                  if (!rw_q && decode_region(32'(addr_q), NUM_CONFIG_REG, NUM_STATUS_REG) == RGN_CONFIG) begin
                     for (int k = 0; k < NUM_CONFIG_REG; k++)
                        if (addr_q == ADDR_WIDTH'(k)) cfg_d[k*DATA_WIDTH +: DATA_WIDTH] = word_v;
                     strobe_d  = 1'b1;
                     wr_addr_d = addr_q;
                  end
`ifdef SPI_REGMAP_BURST_EN
                  addr_d = (32'(addr_q) >= 32'(NUM_REG - 1)) ? '0 : addr_q + 1'b1;
                  load_d = 1'b1;
`else
                  state_d = ST_HOLD;
                  sdo_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: sdo_d = 1'b0;
         default: state_d = ST_IDLE;
      endcase

      // Deselect aborts whatever is in progress; an unfinished word never commits
      if (state_q != ST_IDLE && cs_sync) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         load_d  = 1'b0;
         sdo_d   = 1'b0;
      end

      sdo_oe_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         dout_q     <= '0;
         load_q     <= 1'b0;
         sdo_q      <= 1'b0;
         sdo_oe_q   <= 1'b0;
         cfg_q      <= {NUM_CONFIG_REG{RESET_VAL}};
         strobe_q   <= 1'b0;
         wr_addr_q  <= '0;
         sdi_meta_q <= 1'b0;
         sdi_sync_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         dout_q     <= dout_d;
         load_q     <= load_d;
         sdo_q      <= sdo_d;
         sdo_oe_q   <= sdo_oe_d;
         cfg_q      <= cfg_d;
         strobe_q   <= strobe_d;
         wr_addr_q  <= wr_addr_d;
         sdi_meta_q <= sdi_meta_d;
         sdi_sync_q <= sdi_sync_d;
      end
   end

   assign sdo_o       = sdo_q;
   assign sdo_oe      = sdo_oe_q;
   assign config_o    = cfg_q;
   assign wr_strobe_o = strobe_q;
   assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_spi_regmap_burst.sv
// Directed bench for spi_regmap_burst; expectations follow SPI_REGMAP_BURST_EN.
module tb_spi_regmap_burst;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sck_i, sdi_i, cs_ni;
   logic        sdo_o, sdo_oe;
   logic [95:0] config_o;
   logic [31:0] status_i;
   logic        wr_strobe_o;
   logic [6:0]  wr_addr_o;

   int vectors = 0;
   int miscompares = 0;
   int strobes = 0;

   spi_regmap_burst dut (
      .clk(clk), .rst_n(rst_n), .sck_i(sck_i), .sdi_i(sdi_i), .cs_ni(cs_ni),
      .sdo_o(sdo_o), .sdo_oe(sdo_oe), .config_o(config_o), .status_i(status_i),
      .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o));

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe_o === 1'b1) strobes++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish within 1 ms");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cs_low();
      cs_ni = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      cs_ni = 1'b1;
      sdi_i = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // One sck period per bit: sdi set and sdo sampled in the low phase
   task automatic spi_bits(input logic [63:0] bits, input int n, output logic [63:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         sdi_i = bits[i];
         repeat (4) @(negedge clk);
         rx[i] = sdo_o;
         sck_i = 1'b1;
         repeat (4) @(negedge clk);
         sck_i = 1'b0;
      end
   endtask

   task automatic spi_xfer(input logic [63:0] bits, input int n, output logic [63:0] rx);
      cs_low();
      spi_bits(bits, n, rx);
      cs_high();
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      logic [63:0] rx;
      spi_xfer({48'h0, 1'b0, a, d}, 16, rx);
   endtask

   task automatic do_read(input logic [6:0] a, output logic [7:0] d);
      logic [63:0] rx;
      spi_xfer({48'h0, 1'b1, a, 8'h00}, 16, rx);
      d = rx[7:0];
   endtask

   initial begin
      logic [7:0]  rd;
      logic [63:0] rx;
      logic [95:0] exp_cfg;
      int          s0;

      sck_i = 1'b0; sdi_i = 1'b0; cs_ni = 1'b1; status_i = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_config", config_o, '0);
      check("rst_sdo", sdo_o, 0);
      check("rst_sdo_oe", sdo_oe, 0);
      check("rst_strobe", wr_strobe_o, 0);
      check("rst_wr_addr", wr_addr_o, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_sdo_oe", sdo_oe, 0);

      do_read(7'd0, rd);
      check("rd0_reset", rd, 8'h00);

      s0 = strobes;
      do_write(7'd5, 8'hA5);
      check("wr5_strobes", strobes - s0, 1);
      check("wr5_addr", wr_addr_o, 7'd5);
      check("wr5_cfg", config_o[47:40], 8'hA5);
      do_read(7'd5, rd);
      check("rd5", rd, 8'hA5);

      status_i = 32'hFFFF_0000;
      do_read(7'd12, rd);
      check("rd12_status", rd, 8'h00);
      do_read(7'd14, rd);
      check("rd14_status", rd, 8'hFF);
      s0 = strobes;
      do_write(7'd13, 8'h3C);
      check("wr13_strobes", strobes - s0, 0);
      do_read(7'd13, rd);
      check("rd13_after_wr", rd, 8'h00);
      do_read(7'h40, rd);
      check("rd40_unmapped", rd, 8'h00);

      // Write to reg 3 cut short after 10 bits
      s0 = strobes;
      spi_xfer({48'h0, 1'b0, 7'd3, 8'hFF} >> 6, 10, rx);
      check("abort_strobes", strobes - s0, 0);
      exp_cfg = 96'hA5 << 40;
      check("abort_cfg", config_o, exp_cfg);

      s0 = strobes;
      spi_xfer({1'b0, 7'd10, 56'h11_22_33_44_55_66_77}, 64, rx);
`ifdef SPI_REGMAP_BURST_EN
      check("burst_strobes", strobes - s0, 3);
      check("burst_reg10", config_o[87:80], 8'h11);
      check("burst_reg11", config_o[95:88], 8'h22);
      check("burst_reg0", config_o[7:0], 8'h77);
      check("burst_wr_addr", wr_addr_o, 7'd0);
`else
      check("burst_strobes", strobes - s0, 1);
      check("burst_reg10", config_o[87:80], 8'h11);
      check("burst_reg11", config_o[95:88], 8'h00);
      check("burst_reg0", config_o[7:0], 8'h00);
      check("burst_wr_addr", wr_addr_o, 7'd10);
`endif
      check("burst_reg5", config_o[47:40], 8'hA5);

      spi_xfer({40'h0, 1'b1, 7'd10, 16'h0000}, 24, rx);
      check("rd2_word0", rx[15:8], 8'h11);
`ifdef SPI_REGMAP_BURST_EN
      check("rd2_word1", rx[7:0], 8'h22);
`else
      check("rd2_word1", rx[7:0], 8'h00);
`endif

      // Reset during the data phase of a write to reg 7
      s0 = strobes;
      cs_low();
      check("frame_sdo_oe", sdo_oe, 1);
      spi_bits({48'h0, 1'b0, 7'd7, 8'h99} >> 4, 12, rx);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_cfg", config_o, '0);
      rst_n = 1'b1;
      spi_bits(64'h9, 4, rx);
      check("midrst_sdo_oe", sdo_oe, 0);
      cs_high();
      check("midrst_strobes", strobes - s0, 0);
      check("midrst_reg7", config_o[63:56], 8'h00);
      check("midrst_wr_addr", wr_addr_o, 7'd0);

      s0 = strobes;
      do_write(7'd7, 8'h5A);
      check("wr7_strobes", strobes - s0, 1);
      check("wr7_cfg", config_o[63:56], 8'h5A);
      do_read(7'd7, rd);
      check("rd7", rd, 8'h5A);
      check("end_sdo_oe", sdo_oe, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
